// File: rtl/decim4_avg_feeder_if.sv
// rtl/decim4_avg_feeder_if.sv - I/Q sample stream and Avalon-MM FIFO write bus for decim4_avg_feeder
interface decim4_avg_feeder_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data_i;
  logic signed [DATA_W-1:0] in_data_q;
  logic                     avalonmm_write_master_write;
  logic [2*DATA_W-1:0]      avalonmm_write_master_writedata;
  logic                     avalonmm_write_master_waitrequest;

  modport master (
    input  in_valid,
    input  in_data_i,
    input  in_data_q,
    input  avalonmm_write_master_waitrequest,
    output avalonmm_write_master_write,
    output avalonmm_write_master_writedata
  );

  modport slave (
    output in_valid,
    output in_data_i,
    output in_data_q,
    output avalonmm_write_master_waitrequest,
    input  avalonmm_write_master_write,
    input  avalonmm_write_master_writedata
  );
endinterface

// File: rtl/decim4_avg_feeder.sv
// rtl/decim4_avg_feeder.sv - group-average I/Q decimator feeding a FIFO write slave
// Optional DECIM4_OVF_COUNT_EN adds a saturating 16-bit dropped-result counter (ovf_count).
module decim4_avg_feeder #(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                   wrclock,
  input  logic                   wrreset,
  decim4_avg_feeder_if.master    bus,
  output logic                   ovf_pulse
`ifdef DECIM4_OVF_COUNT_EN
  ,
  output logic [15:0]            ovf_count
`endif
);
  localparam int AW = DATA_W + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] PH_LAST = '1;
  localparam logic signed [AW-1:0]  HALF    = AW'(2 ** (DECIM_LOG2 - 1));

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic signed [AW-1:0]  acc_i_q, acc_i_d;
  logic signed [AW-1:0]  acc_q_q, acc_q_d;
  logic                  write_q, write_d;
  logic [2*DATA_W-1:0]   wdata_q, wdata_d;
  logic                  ovf_q, ovf_d;

  logic signed [AW-1:0]     smp_i, smp_q, sum_i, sum_q, rnd_i, rnd_q;
  logic signed [DATA_W-1:0] avg_i, avg_q;
  logic                     grp_done, stalled, accepted;

  always_comb begin
    smp_i = {{DECIM_LOG2{bus.in_data_i[DATA_W-1]}}, bus.in_data_i};
    smp_q = {{DECIM_LOG2{bus.in_data_q[DATA_W-1]}}, bus.in_data_q};
    sum_i = acc_i_q + smp_i;
    sum_q = acc_q_q + smp_q;
    // Round half up; the accumulator has enough headroom that this never wraps.
    rnd_i = sum_i + HALF;
    rnd_q = sum_q + HALF;
    avg_i = DATA_W'(rnd_i >>> DECIM_LOG2);
    avg_q = DATA_W'(rnd_q >>> DECIM_LOG2);

    grp_done = bus.in_valid && (phase_q == PH_LAST);
    stalled  = write_q && bus.avalonmm_write_master_waitrequest;
    accepted = write_q && !bus.avalonmm_write_master_waitrequest;

    phase_d = phase_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ovf_d   = 1'b0;

    if (bus.in_valid) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == '0) begin
        acc_i_d = smp_i;
        acc_q_d = smp_q;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end

    if (accepted) begin
      write_d = 1'b0;
    end

    // A stalled pending word wins; a new result arriving then is dropped.
    if (grp_done) begin
      if (stalled) begin
        ovf_d = 1'b1;
      end else begin
        write_d = 1'b1;
        wdata_d = {avg_i, avg_q};
      end
    end
  end

  always_ff @(posedge wrclock) begin
    if (wrreset) begin
      phase_q <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DECIM4_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_d && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wrclock) begin
    if (wrreset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

  assign bus.avalonmm_write_master_write     = write_q;
  assign bus.avalonmm_write_master_writedata = wdata_q;
  assign ovf_pulse                           = ovf_q;
endmodule
